// File: rtl/universal_shift_register_n.sv
// universal_shift_register_n: multi-step shift/rotate/load register with busy/done handshake
module universal_shift_register_n #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] data_in,
  input  logic             left_in,
  input  logic             right_in,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  logic [0:0]       state_q, state_d;
  logic [2:0]       mode_q, mode_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             done_q, done_d;
  logic             multi;
  function automatic logic [WIDTH-1:0] step(input logic [2:0] m, input logic [WIDTH-1:0] v,
                                             input logic li, input logic ri);
    return m == 3'b001 ? {v[WIDTH-2:0], ri} :
           m == 3'b010 ? {li, v[WIDTH-1:1]} :
           m == 3'b100 ? {v[WIDTH-2:0], v[WIDTH-1]} :
           m == 3'b101 ? {v[0], v[WIDTH-1:1]} :
           m == 3'b110 ? {v[WIDTH-1], v[WIDTH-1:1]} : v;
  endfunction
  assign multi = (count != '0) && (mode inside {3'b001, 3'b010, 3'b100, 3'b101, 3'b110});
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    q_d     = q_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (start && multi) begin
        state_d = RUN;
        mode_d  = mode;
        rem_d   = count;
      end else if (start) begin
        done_d = 1'b1;
        q_d    = mode == 3'b011 ? data_in : q_q;
      end
    end else begin
      q_d     = step(mode_q, q_q, left_in, right_in);
      rem_d   = rem_q - CNT_W'(1);
      state_d = rem_q == CNT_W'(1) ? IDLE : RUN;
      done_d  = rem_q == CNT_W'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      mode_q  <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      done_q  <= done_d;
    end
  end
  assign q    = q_q;
  assign busy = state_q == RUN;
  assign done = done_q;
endmodule
